// File: rtl/debounce_pkg.sv
// Shared types for the multi-channel button debouncer.
// Holds the channel FSM state encoding and the counter width helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        CONFIRM_PRESS,
        HELD,
        CONFIRM_RELEASE
    } state_t;

    // Width able to hold 0..max_val, never narrower than one bit
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: synchroniser, confirm/held FSM and auto-repeat.
// Exposes its next press value so the top can register any_press in step.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 5,
    parameter int ACTIVE_LOW      = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_noisy,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_press_nxt
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = cnt_width(REPEAT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [RW-1:0] RPT_LAST =
        RW'(REPEAT_CYCLES > 0 ? REPEAT_CYCLES - 1 : 0);
    localparam logic IDLE_RAW = (ACTIVE_LOW != 0);
    localparam logic [SYNC_STAGES-1:0] SYNC_RST = {SYNC_STAGES{IDLE_RAW}};

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [RW-1:0]          r_rpt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;

    state_t        w_state;
    logic [CW-1:0] w_cnt;
    logic [RW-1:0] w_rpt;
    logic          w_level;
    logic          w_press;
    logic          w_release;
    logic          w_rpt_run;
    logic          w_p;

    assign w_p = r_sync[SYNC_STAGES-1] ^ IDLE_RAW;

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_rpt     = r_rpt;
        w_level   = r_level;
        w_press   = 1'b0;
        w_release = 1'b0;
        w_rpt_run = 1'b0;
        unique case (r_state)
            RELEASED: begin
                if (w_p) begin
                    w_state = CONFIRM_PRESS;
                    w_cnt   = CW'(1);
                end
            end
            CONFIRM_PRESS: begin
                if (!w_p) begin
                    w_state = RELEASED;
                    w_cnt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state = HELD;
                    w_cnt   = '0;
                    w_rpt   = '0;
                    w_level = 1'b1;
                    w_press = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                w_rpt_run = 1'b1;
                if (!w_p) begin
                    w_state = CONFIRM_RELEASE;
                    w_cnt   = CW'(1);
                end
            end
            CONFIRM_RELEASE: begin
                if (w_p) begin
                    w_state   = HELD;
                    w_cnt     = '0;
                    w_rpt_run = 1'b1;
                end else if (r_cnt == CNT_MAX) begin
                    w_state   = RELEASED;
                    w_cnt     = '0;
                    w_rpt     = '0;
                    w_level   = 1'b0;
                    w_release = 1'b1;
                end else begin
                    w_cnt     = r_cnt + 1'b1;
                    w_rpt_run = 1'b1;
                end
            end
        endcase
        // An accepted release suppresses w_rpt_run, so it wins over a repeat
        if (REPEAT_CYCLES > 0 && w_rpt_run) begin
            if (r_rpt == RPT_LAST) begin
                w_rpt   = '0;
                w_press = 1'b1;
            end else begin
                w_rpt = r_rpt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync    <= SYNC_RST;
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_rpt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_noisy};
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_rpt     <= w_rpt;
            r_level   <= w_level;
            r_press   <= w_press;
            r_release <= w_release;
        end
    end

    assign o_level     = r_level;
    assign o_press     = r_press;
    assign o_release   = r_release;
    assign o_press_nxt = w_press;

endmodule

// File: rtl/multi_debouncer.sv
// N independent button debouncers with a combined press indicator.
// any_press is registered from the channels' next press values.
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 5,
    parameter int ACTIVE_LOW      = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisy_button,
    output logic [CHANNELS-1:0] clean_level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                any_press
);

    logic [CHANNELS-1:0] w_press_nxt;
    logic                r_any;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .SYNC_STAGES     (SYNC_STAGES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .i_noisy     (noisy_button[g]),
            .o_level     (clean_level[g]),
            .o_press     (press_pulse[g]),
            .o_release   (release_pulse[g]),
            .o_press_nxt (w_press_nxt[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_press_nxt;
        end
    end

    assign any_press = r_any;

endmodule
